// File: rtl/tb_monitor_pkg.sv
// ============================================================================
// Module : tb_monitor_pkg
// Brief  : Shared session-state encoding and default port/symbol constants.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tb_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CAPTURE = 2'b01,
        DONE    = 2'b10
    } state_t;

    localparam logic [29:0] TEST_PORT_DEFAULT = 30'hFF;
    localparam logic [31:0] BEGIN_SYM_DEFAULT = 32'h0000_0932;
    localparam logic [31:0] END_SYM_DEFAULT   = 32'h0000_0D5D;

endpackage

`default_nettype wire

// File: rtl/tb_sync_fifo.sv
// ============================================================================
// Module : tb_sync_fifo
// Brief  : Synchronous first-word-fall-through FIFO with a registered head word.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       rd_next;
    logic              do_push;
    logic              do_pop;
    logic              empty_after_pop;

    assign empty           = (wr_ptr == rd_ptr);
    assign full            = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop          = pop & ~empty;
    assign do_push         = push & (~full | do_pop);
    assign rd_next         = rd_ptr + (AW+1)'(do_pop);
    assign empty_after_pop = (rd_next == wr_ptr);

    // Head is reloaded from the slot the read pointer lands on; when the
    // queue drains to empty it either takes the incoming word or holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_next;
            if (empty_after_pop) begin
                if (do_push) head <= push_data;
            end else begin
                head <= mem[rd_next[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/tb_store_port_monitor.sv
// ============================================================================
// Module : tb_store_port_monitor
// Brief  : Frames stores to the test port into a buffered valid/ready stream.
//          Option macro: TB_MONITOR_WEN_EDGE_EN (wen rising-edge event detect).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_store_port_monitor
    import tb_monitor_pkg::*;
#(
    parameter logic [29:0] TEST_PORT = TEST_PORT_DEFAULT,
    parameter logic [31:0] BEGIN_SYM = BEGIN_SYM_DEFAULT,
    parameter logic [31:0] END_SYM   = END_SYM_DEFAULT,
    parameter int          DEPTH     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] addr,
    input  logic [31:0] data,
    input  logic        wen,
    input  logic        stall,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        out_last,
    output logic        capturing,
    output logic        done,
    output logic        overflow,
    output logic [15:0] word_count
);

    state_t state;
    state_t state_next;
    logic   addr_hit;
    logic   evt;
    logic   push;
    logic   full;
    logic   empty;
    logic   accepted;

    assign addr_hit = (addr == TEST_PORT);

`ifdef TB_MONITOR_WEN_EDGE_EN
    // Cores that hold wen through a stall: fire once per wen assertion.
    logic write_seen;
    logic unused_stall;

    assign unused_stall = stall;
    assign evt          = wen & addr_hit & ~write_seen;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) write_seen <= 1'b0;
        else      write_seen <= wen & (write_seen | addr_hit);
    end
`else
    assign evt = wen & ~stall & addr_hit;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (evt && data == BEGIN_SYM) state_next = CAPTURE;
            CAPTURE: if (evt && data == END_SYM)   state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        push      = evt && (state == CAPTURE);
        capturing = (state == CAPTURE);
        done      = (state == DONE);
    end

    tb_sync_fifo #(
        .DATA_W (32),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (data),
        .pop       (out_ready),
        .full      (full),
        .empty     (empty),
        .head      (out_data)
    );

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign accepted  = push & (~full | (out_ready & ~empty));
    assign out_valid = ~empty;
    assign out_last  = out_valid & (out_data == END_SYM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow   <= 1'b0;
            word_count <= 16'h0000;
        end else begin
            if (push && !accepted) overflow <= 1'b1;
            if (accepted && word_count != 16'hFFFF) word_count <= word_count + 16'd1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tb_store_port_monitor.sv
// ============================================================================
// Module : tb_tb_store_port_monitor
// Brief  : Self-checking bench: vector table, directed corners, random vs model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tb_store_port_monitor;

    localparam logic [29:0] PORT  = 30'hFF;
    localparam logic [31:0] BEG   = 32'h0000_0932;
    localparam logic [31:0] ENDS  = 32'h0000_0D5D;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] addr;
    logic [31:0] data;
    logic        wen;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        out_last;
    logic        capturing;
    logic        done;
    logic        overflow;
    logic [15:0] word_count;

    int tests = 0;
    int fails = 0;

    tb_store_port_monitor #(
        .TEST_PORT (PORT),
        .BEGIN_SYM (BEG),
        .END_SYM   (ENDS),
        .DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .data       (data),
        .wen        (wen),
        .stall      (stall),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .capturing  (capturing),
        .done       (done),
        .overflow   (overflow),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    // Reference model: session phase, queue of buffered words, sticky flag, count.
    localparam int M_IDLE = 0, M_CAP = 1, M_DONE = 2;
    int          m_phase;
    logic [31:0] mq[$];
    bit          m_ovf;
    int          m_cnt;

    task automatic model_reset();
        m_phase = M_IDLE;
        mq.delete();
        m_ovf = 0;
        m_cnt = 0;
    endtask

    task automatic model_edge(input logic w, input logic s, input logic [29:0] a,
                              input logic [31:0] d, input logic r);
        bit fired;
        if (mq.size() > 0 && r) void'(mq.pop_front());
        fired = w && !s && (a == PORT);
        if (fired) begin
            if (m_phase == M_IDLE) begin
                if (d == BEG) m_phase = M_CAP;
            end else if (m_phase == M_CAP) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(d);
                    if (m_cnt < 65535) m_cnt++;
                end else begin
                    m_ovf = 1;
                end
                if (d == ENDS) m_phase = M_DONE;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("valid", 32'(out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) chk("data", out_data, mq[0]);
        chk("last", 32'(out_last), 32'(mq.size() > 0 && mq[0] == ENDS));
        chk("capturing", 32'(capturing), 32'(m_phase == M_CAP));
        chk("done", 32'(done), 32'(m_phase == M_DONE));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("word_count", 32'(word_count), 32'(m_cnt));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, compare.
    task automatic cyc(input logic w, input logic s, input logic [29:0] a,
                       input logic [31:0] d, input logic r);
        wen = w; stall = s; addr = a; data = d; out_ready = r;
        @(posedge clk);
        if (rst) model_edge(w, s, a, d, r);
        #1;
        check_model();
    endtask

    task automatic store(input logic [31:0] d, input logic r);
        cyc(1'b1, 1'b0, PORT, d, r);
    endtask

    task automatic idle(input logic r);
        cyc(1'b0, 1'b0, PORT, 32'h0, r);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        idle(1'b0);
        rst = 1'b1;
    endtask

    typedef struct {
        logic        wen;
        logic [31:0] data;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_last;
        logic        e_cap;
        logic        e_done;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int got;
        logic [31:0] last_word;

        vecs[0] = '{1'b1, BEG,   1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 16'd0};
        vecs[1] = '{1'b1, 32'd1, 1'b1, 32'd1,  1'b0, 1'b1, 1'b0, 16'd1};
        vecs[2] = '{1'b1, 32'd2, 1'b1, 32'd2,  1'b0, 1'b1, 1'b0, 16'd2};
        vecs[3] = '{1'b1, 32'd3, 1'b1, 32'd3,  1'b0, 1'b1, 1'b0, 16'd3};
        vecs[4] = '{1'b1, ENDS,  1'b1, ENDS,   1'b1, 1'b0, 1'b1, 16'd4};
        vecs[5] = '{1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 16'd4};

        rst = 1'b0; wen = 1'b0; stall = 1'b0; addr = '0; data = '0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model();
        rst = 1'b1;

        // Normal session from the table, out_ready held high
        for (int i = 0; i < 6; i++) begin
            cyc(vecs[i].wen, 1'b0, PORT, vecs[i].data, 1'b1);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid) chk($sformatf("vec%0d_data", i), out_data, vecs[i].e_data);
            chk($sformatf("vec%0d_last", i), 32'(out_last), 32'(vecs[i].e_last));
            chk($sformatf("vec%0d_cap", i), 32'(capturing), 32'(vecs[i].e_cap));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].e_done));
            chk($sformatf("vec%0d_cnt", i), 32'(word_count), 32'(vecs[i].e_cnt));
        end

        // Stalled store collapses to one word, visible one cycle after stall falls
        do_reset();
        store(BEG, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, PORT, 32'd7, 1'b1);
            chk("stall_no_word", 32'(out_valid), 32'd0);
        end
        cyc(1'b1, 1'b0, PORT, 32'd7, 1'b1);
        chk("stall_word_valid", 32'(out_valid), 32'd1);
        chk("stall_word_data", out_data, 32'd7);
        idle(1'b1);
        chk("stall_single", 32'(word_count), 32'd1);

        // Pre-begin and wrong-address stores are filtered out
        do_reset();
        store(32'd5, 1'b1);
        store(BEG, 1'b1);
        cyc(1'b1, 1'b0, 30'h10, 32'd9, 1'b1);
        idle(1'b1);
        chk("filter_valid", 32'(out_valid), 32'd0);
        chk("filter_cnt", 32'(word_count), 32'd0);

        // Overflow: nine pushes into eight slots, then drain in order
        do_reset();
        store(BEG, 1'b0);
        for (int i = 0; i < 9; i++) store(32'h100 + 32'(i), 1'b0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_cnt", 32'(word_count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf_drain%0d", i), out_data, 32'h100 + 32'(i));
            idle(1'b1);
        end
        chk("ovf_empty", 32'(out_valid), 32'd0);

        // Full with simultaneous push and pop
        do_reset();
        store(BEG, 1'b0);
        for (int i = 0; i < 8; i++) store(32'h200 + 32'(i), 1'b0);
        store(32'h55, 1'b1);
        chk("fullpp_ovf", 32'(overflow), 32'd0);
        got = 0;
        last_word = 32'h0;
        while (out_valid && got < 20) begin
            last_word = out_data;
            got++;
            idle(1'b1);
        end
        chk("fullpp_count", 32'(got), 32'd8);
        chk("fullpp_last", last_word, 32'h55);

        // Asynchronous reset mid-session
        do_reset();
        store(BEG, 1'b0);
        store(32'd1, 1'b0);
        store(32'd2, 1'b0);
        store(32'd3, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_cap", 32'(capturing), 32'd0);
        chk("rst_cnt", 32'(word_count), 32'd0);
        model_reset();
        idle(1'b0);
        rst = 1'b1;
        store(32'd5, 1'b1);
        idle(1'b1);
        chk("rst_ignored", 32'(out_valid), 32'd0);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic [31:0] d;
            int pick;
            if ($urandom_range(0, 79) == 0) begin
                do_reset();
            end else begin
                pick = int'($urandom_range(0, 19));
                d = (pick < 3) ? BEG : (pick == 3) ? ENDS : $urandom;
                cyc($urandom_range(0, 9) < 6,
                    $urandom_range(0, 3) == 0,
                    ($urandom_range(0, 3) != 0) ? PORT : 30'($urandom),
                    d,
                    $urandom_range(0, 1) == 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
